// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared encodings for the pipeline hazard/forwarding controller:
//   instruction class codes presented in ID, the forward-select code for
//   "take the register file value", and the controller FSM state encoding.
//   No ports (package).

package hazard_pkg;

    localparam logic [1:0] CLS_ALU  = 2'd0;
    localparam logic [1:0] CLS_LOAD = 2'd1;
    localparam logic [1:0] CLS_MUL  = 2'd2;

    localparam int FWD_REGFILE = 0;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

endpackage

// File: rtl/hazard_match.sv
// hazard_match
//   Combinational youngest-slot priority matcher for one source operand.
//   Scans the in-flight scoreboard slots and reports the lowest-index slot
//   whose pending write targets the source register.
//
//   Ports
//     src        in   source register address
//     use_src    in   instruction actually reads this source
//     slot_valid in   per-slot valid (bit 0 = slot1 = EX)
//     slot_wr    in   per-slot register-write flag
//     slot_dest  in   per-slot destination, slot j at [j*REG_AW +: REG_AW]
//     slot_busy  in   per-slot "result not yet forwardable" (rdy_cnt != 0)
//     hit        out  a slot matches
//     slot_idx   out  1-based index of youngest matching slot, 0 when no hit
//     pending    out  youngest matching slot is not yet forwardable

module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int FW     = $clog2(DEPTH + 1)
) (
    input  logic [REG_AW-1:0]       src,
    input  logic                    use_src,
    input  logic [DEPTH-1:0]        slot_valid,
    input  logic [DEPTH-1:0]        slot_wr,
    input  logic [DEPTH*REG_AW-1:0] slot_dest,
    input  logic [DEPTH-1:0]        slot_busy,
    output logic                    hit,
    output logic [FW-1:0]           slot_idx,
    output logic                    pending
);

    // Walk from oldest to youngest so the youngest match is written last.
    always_comb begin
        hit      = 1'b0;
        slot_idx = FW'(FWD_REGFILE);
        pending  = 1'b0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (use_src && slot_valid[j] && slot_wr[j] && (src != '0) &&
                (slot_dest[j*REG_AW +: REG_AW] == src)) begin
                hit      = 1'b1;
                slot_idx = FW'(j + 1);
                pending  = slot_busy[j];
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and forwarding controller for the in-order pipeline. A DEPTH-slot
//   scoreboard (slot1 = EX ... slotDEPTH = WB) tracks in-flight destinations.
//   Load-use hazards stall ID; a multi-cycle MUL freezes the whole pipe.
//   Forward selects are registered at issue and consumed in EX; a select of 0
//   means register file, which must write-through a same-cycle WB result.
//
//   Ports
//     clk_i          in   clock
//     rst_i          in   synchronous reset, active low
//     id_valid_i     in   ID holds a real instruction
//     id_rs_i/rt_i   in   source addresses
//     id_use_rs_i/rt in   source actually read
//     id_rd_i        in   destination address
//     id_wr_i        in   instruction writes a register
//     id_class_i     in   ALU=0, LOAD=1, MUL=2
//     flush_i        in   taken branch/jump resolved in ID
//     pc_hold_o      out  PC keeps its value
//     ifid_hold_o    out  IF/ID keeps its contents
//     ifid_clear_o   out  IF/ID loads a bubble
//     idex_bubble_o  out  ID/EX loads a bubble
//     freeze_o       out  all pipeline registers hold
//     fwd_rs_o/rt_o  out  EX operand source: 0=reg file, k=slot k result
//     stall_cnt_o    out  saturating count of stall and freeze cycles
//
//   state | meaning
//   IDLE  | normal flow; load-use stalls may be raised
//   BUSY  | MUL occupying EX; whole pipe frozen for MUL_LAT-1 cycles

module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int MUL_LAT  = 4,
    parameter int CNT_W    = 16,
    parameter int FW       = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_wr_i,
    input  logic [1:0]        id_class_i,
    input  logic              flush_i,
    output logic              pc_hold_o,
    output logic              ifid_hold_o,
    output logic              ifid_clear_o,
    output logic              idex_bubble_o,
    output logic              freeze_o,
    output logic [FW-1:0]     fwd_rs_o,
    output logic [FW-1:0]     fwd_rt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int RW = $clog2(DEPTH);
    localparam int MW = 5;

    logic                         state;
    logic [MW-1:0]                mul_cnt;
    logic [DEPTH-1:0]             slot_valid;
    logic [DEPTH-1:0]             slot_wr;
    logic [DEPTH-1:0][REG_AW-1:0] slot_dest;
    logic [DEPTH-1:0][RW-1:0]     slot_rdy;
    logic [DEPTH-1:0]             slot_busy;

    logic          rs_hit, rt_hit, rs_pend, rt_pend;
    logic [FW-1:0] rs_slot, rt_slot;
    logic          stall, busy, issue, mul_start;

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            slot_busy[j] = |slot_rdy[j];
        end
    end

    hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FW(FW)) u_match_rs (
        .src        (id_rs_i),
        .use_src    (id_use_rs_i),
        .slot_valid (slot_valid),
        .slot_wr    (slot_wr),
        .slot_dest  (slot_dest),
        .slot_busy  (slot_busy),
        .hit        (rs_hit),
        .slot_idx   (rs_slot),
        .pending    (rs_pend)
    );

    hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FW(FW)) u_match_rt (
        .src        (id_rt_i),
        .use_src    (id_use_rt_i),
        .slot_valid (slot_valid),
        .slot_wr    (slot_wr),
        .slot_dest  (slot_dest),
        .slot_busy  (slot_busy),
        .hit        (rt_hit),
        .slot_idx   (rt_slot),
        .pending    (rt_pend)
    );

    assign busy      = (state == ST_BUSY);
    assign stall     = id_valid_i && !busy && ((rs_hit && rs_pend) || (rt_hit && rt_pend));
    assign issue     = id_valid_i && !stall && !busy;
    assign mul_start = issue && (id_class_i == CLS_MUL) && (MUL_LAT > 1);

    assign pc_hold_o     = stall;
    assign ifid_hold_o   = stall;
    assign idex_bubble_o = stall;
    assign freeze_o      = busy;
    // Branch operands are not valid while stalled or frozen, so the flush waits.
    assign ifid_clear_o  = flush_i && !stall && !busy;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= ST_IDLE;
            mul_cnt     <= '0;
            slot_valid  <= '0;
            slot_wr     <= '0;
            slot_dest   <= '0;
            slot_rdy    <= '0;
            fwd_rs_o    <= FW'(FWD_REGFILE);
            fwd_rt_o    <= FW'(FWD_REGFILE);
            stall_cnt_o <= '0;
        end else begin
            if ((stall || busy) && !(&stall_cnt_o)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end

            if (!busy) begin
                slot_valid[0] <= issue;
                slot_wr[0]    <= issue && id_wr_i;
                slot_dest[0]  <= id_rd_i;
                slot_rdy[0]   <= (issue && (id_class_i == CLS_LOAD)) ? RW'(LOAD_LAT - 1) : '0;
                for (int k = 1; k < DEPTH; k++) begin
                    slot_valid[k] <= slot_valid[k-1];
                    slot_wr[k]    <= slot_wr[k-1];
                    slot_dest[k]  <= slot_dest[k-1];
                    slot_rdy[k]   <= slot_busy[k-1] ? slot_rdy[k-1] - 1'b1 : '0;
                end
                fwd_rs_o <= issue ? rs_slot : FW'(FWD_REGFILE);
                fwd_rt_o <= issue ? rt_slot : FW'(FWD_REGFILE);
            end

            case (state)
                ST_IDLE: begin
                    if (mul_start) begin
                        state   <= ST_BUSY;
                        mul_cnt <= MW'(MUL_LAT - 1);
                    end
                end
                default: begin
                    mul_cnt <= mul_cnt - 1'b1;
                    if (mul_cnt == MW'(1)) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: two instances (default parameters and a
// deeper, slower-load, single-cycle-MUL, 2-bit-counter variant) driven by the
// same ID stream and checked against an age-based reference model.

module tb_pipe_hazard_ctrl;
    import hazard_pkg::*;

    localparam int A_DEPTH = 3, A_LL = 2, A_ML = 4, A_CW = 16;
    localparam int B_DEPTH = 5, B_LL = 3, B_ML = 1, B_CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, id_valid, use_rs, use_rt, wr, flush;
    logic [4:0] rs, rt, rd;
    logic [1:0] cls;

    logic ph_a, ih_a, ic_a, ib_a, fz_a;
    logic [1:0] frs_a, frt_a;
    logic [A_CW-1:0] sc_a;
    logic ph_b, ih_b, ic_b, ib_b, fz_b;
    logic [2:0] frs_b, frt_b;
    logic [B_CW-1:0] sc_b;

    pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(A_DEPTH), .LOAD_LAT(A_LL), .MUL_LAT(A_ML), .CNT_W(A_CW)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid), .id_rs_i(rs), .id_rt_i(rt),
        .id_use_rs_i(use_rs), .id_use_rt_i(use_rt), .id_rd_i(rd), .id_wr_i(wr),
        .id_class_i(cls), .flush_i(flush), .pc_hold_o(ph_a), .ifid_hold_o(ih_a),
        .ifid_clear_o(ic_a), .idex_bubble_o(ib_a), .freeze_o(fz_a),
        .fwd_rs_o(frs_a), .fwd_rt_o(frt_a), .stall_cnt_o(sc_a)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(B_DEPTH), .LOAD_LAT(B_LL), .MUL_LAT(B_ML), .CNT_W(B_CW)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid), .id_rs_i(rs), .id_rt_i(rt),
        .id_use_rs_i(use_rs), .id_use_rt_i(use_rt), .id_rd_i(rd), .id_wr_i(wr),
        .id_class_i(cls), .flush_i(flush), .pc_hold_o(ph_b), .ifid_hold_o(ih_b),
        .ifid_clear_o(ic_b), .idex_bubble_o(ib_b), .freeze_o(fz_b),
        .fwd_rs_o(frs_b), .fwd_rt_o(frt_b), .stall_cnt_o(sc_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each issued producer is a record with an age
    // (1 = just issued into EX). Ages advance on every unfrozen cycle and the
    // record retires once older than DEPTH.
    int   p_depth[2], p_ll[2], p_ml[2], p_cmax[2];
    bit   r_used[2][8];
    int   r_age[2][8];
    logic [4:0] r_dest[2][8];
    bit   r_wr[2][8];
    bit   r_load[2][8];
    int   m_busy[2], m_frs[2], m_frt[2], m_cnt[2];

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int p);
        for (int e = 0; e < 8; e++) r_used[p][e] = 1'b0;
        m_busy[p] = 0;
        m_frs[p]  = 0;
        m_frt[p]  = 0;
        m_cnt[p]  = 0;
    endtask

    function automatic void find(input int p, input logic [4:0] src, input logic use_src,
                                 output int code, output bit pend);
        int best = 99;
        code = 0;
        pend = 1'b0;
        if (!use_src || src == 5'd0) return;
        for (int e = 0; e < 8; e++) begin
            if (r_used[p][e] && r_wr[p][e] && r_dest[p][e] == src && r_age[p][e] < best) begin
                best = r_age[p][e];
                code = best;
                pend = r_load[p][e] && (best < p_ll[p]);
            end
        end
    endfunction

    task automatic model_cycle(input int p, input int ph, input int ih, input int ic,
                               input int ib, input int fz, input int frs, input int frt,
                               input int sc);
        int    crs, crt, slot;
        bit    prs, prt, busy, stall, issue;
        string n;
        n    = (p == 0) ? "a." : "b.";
        busy = m_busy[p] > 0;
        find(p, rs, use_rs, crs, prs);
        find(p, rt, use_rt, crt, prt);
        stall = id_valid && !busy && (prs || prt);
        chk({n, "pc_hold"},     ph,  int'(stall));
        chk({n, "ifid_hold"},   ih,  int'(stall));
        chk({n, "idex_bubble"}, ib,  int'(stall));
        chk({n, "ifid_clear"},  ic,  int'(flush && !stall && !busy));
        chk({n, "freeze"},      fz,  int'(busy));
        chk({n, "fwd_rs"},      frs, m_frs[p]);
        chk({n, "fwd_rt"},      frt, m_frt[p]);
        chk({n, "stall_cnt"},   sc,  m_cnt[p]);
        if (!rst_n) begin
            model_clear(p);
        end else begin
            if ((stall || busy) && m_cnt[p] < p_cmax[p]) m_cnt[p]++;
            if (busy) begin
                m_busy[p]--;
            end else begin
                issue = id_valid && !stall;
                for (int e = 0; e < 8; e++) begin
                    if (r_used[p][e]) begin
                        r_age[p][e]++;
                        if (r_age[p][e] > p_depth[p]) r_used[p][e] = 1'b0;
                    end
                end
                if (issue) begin
                    slot = -1;
                    for (int e = 0; e < 8; e++) if (!r_used[p][e] && slot < 0) slot = e;
                    if (slot >= 0) begin
                        r_used[p][slot] = 1'b1;
                        r_age[p][slot]  = 1;
                        r_dest[p][slot] = rd;
                        r_wr[p][slot]   = wr;
                        r_load[p][slot] = (cls == CLS_LOAD);
                    end
                    if (cls == CLS_MUL && p_ml[p] > 1) m_busy[p] = p_ml[p] - 1;
                end
                m_frs[p] = issue ? crs : 0;
                m_frt[p] = issue ? crt : 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle(0, ph_a, ih_a, ic_a, ib_a, fz_a, frs_a, frt_a, sc_a);
        model_cycle(1, ph_b, ih_b, ic_b, ib_b, fz_b, frs_b, frt_b, sc_b);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic [1:0] c, input int d, input logic w,
                         input int s, input logic us, input int t, input logic ut);
        id_valid = v;
        cls      = c;
        rd       = 5'(d);
        wr       = w;
        rs       = 5'(s);
        use_rs   = us;
        rt       = 5'(t);
        use_rt   = ut;
        flush    = 1'b0;
    endtask

    task automatic idle();
        instr(1'b0, CLS_ALU, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic reset_all();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        p_depth[0] = A_DEPTH; p_ll[0] = A_LL; p_ml[0] = A_ML; p_cmax[0] = (1 << A_CW) - 1;
        p_depth[1] = B_DEPTH; p_ll[1] = B_LL; p_ml[1] = B_ML; p_cmax[1] = (1 << B_CW) - 1;
        model_clear(0);
        model_clear(1);
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_freeze", fz_a, 0);
        chk("rst_fwd_rs", frs_a, 0);
        chk("rst_cnt", sc_a, 0);
        chk("rst_hold", ph_a, 0);

        // Load-use, back to back.
        instr(1'b1, CLS_LOAD, 8, 1'b1, 0, 1'b0, 0, 1'b0); step();
        instr(1'b1, CLS_ALU, 9, 1'b1, 8, 1'b1, 1, 1'b1);  step();
        step();
        chk("lu_fwd_a", frs_a, 2);
        chk("lu_cnt_a", sc_a, 1);
        step();
        chk("lu_fwd_b", frs_b, 3);
        chk("lu_cnt_b", sc_b, 2);
        chk("lu_cnt_a2", sc_a, 1);

        // ALU forwarding chain across all slots.
        reset_all();
        instr(1'b1, CLS_ALU, 8, 1'b1, 0, 1'b0, 0, 1'b0);  step();
        instr(1'b1, CLS_ALU, 10, 1'b1, 8, 1'b1, 0, 1'b0); step();
        chk("chain1_a", frs_a, 1); chk("chain1_b", frs_b, 1);
        instr(1'b1, CLS_ALU, 11, 1'b1, 8, 1'b1, 0, 1'b0); step();
        chk("chain2_a", frs_a, 2); chk("chain2_b", frs_b, 2);
        instr(1'b1, CLS_ALU, 12, 1'b1, 0, 1'b0, 8, 1'b1); step();
        chk("chain3_a", frt_a, 3); chk("chain3_b", frt_b, 3);
        instr(1'b1, CLS_ALU, 13, 1'b1, 8, 1'b1, 0, 1'b0); step();
        chk("chain4_a", frs_a, 0); chk("chain4_b", frs_b, 4);
        chk("chain_cnt", sc_a, 0);

        // Multi-cycle MUL freeze, then dependent issue.
        reset_all();
        instr(1'b1, CLS_MUL, 5, 1'b1, 0, 1'b0, 0, 1'b0); step();
        chk("mul_frz_a", fz_a, 1);
        chk("mul_frz_b", fz_b, 0);
        instr(1'b1, CLS_ALU, 6, 1'b1, 5, 1'b1, 0, 1'b0);
        repeat (3) step();
        chk("mul_end_frz", fz_a, 0);
        chk("mul_cnt_a", sc_a, 3);
        step();
        chk("mul_fwd_a", frs_a, 1);
        chk("mul_fwd_b", frs_b, 4);

        // r0 never creates a hazard; a flush does not override a stall.
        reset_all();
        instr(1'b1, CLS_ALU, 0, 1'b1, 0, 1'b0, 0, 1'b0);  step();
        instr(1'b1, CLS_ALU, 7, 1'b1, 0, 1'b1, 0, 1'b1);  step();
        instr(1'b1, CLS_LOAD, 0, 1'b1, 0, 1'b0, 0, 1'b0); step();
        instr(1'b1, CLS_ALU, 7, 1'b1, 0, 1'b1, 0, 1'b1);  step();
        chk("r0_cnt", sc_a, 0);
        instr(1'b1, CLS_LOAD, 8, 1'b1, 0, 1'b0, 0, 1'b0); step();
        instr(1'b1, CLS_ALU, 9, 1'b1, 8, 1'b1, 0, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush_hold", ph_a, 1);
        chk("flush_clear", ic_a, 0);
        step();
        flush = 1'b0;
        step();
        chk("flush_cnt", sc_a, 1);

        // Reset during the second BUSY cycle.
        reset_all();
        instr(1'b1, CLS_ALU, 3, 1'b1, 0, 1'b0, 0, 1'b0); step();
        instr(1'b1, CLS_MUL, 5, 1'b1, 3, 1'b1, 0, 1'b0); step();
        chk("busy_pre_fwd", frs_a, 1);
        idle(); step();
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        chk("busy_rst_frz", fz_a, 0);
        chk("busy_rst_fwd", frs_a, 0);
        chk("busy_rst_cnt", sc_a, 0);
        instr(1'b1, CLS_LOAD, 8, 1'b1, 0, 1'b0, 0, 1'b0); step();
        instr(1'b1, CLS_ALU, 9, 1'b1, 8, 1'b1, 0, 1'b0);  step(); step();
        chk("post_rst_fwd", frs_a, 2);
        chk("post_rst_cnt", sc_a, 1);
        step();
        instr(1'b1, CLS_LOAD, 10, 1'b1, 0, 1'b0, 0, 1'b0); step();
        instr(1'b1, CLS_ALU, 11, 1'b1, 10, 1'b1, 0, 1'b0); repeat (3) step();
        chk("sat_cnt_b", sc_b, 3);
        chk("sat_cnt_a", sc_a, 2);

        // Randomized traffic on a small register set to force collisions.
        for (int i = 0; i < 800; i++) begin
            rst_n    = ($urandom_range(0, 63) != 0);
            id_valid = ($urandom_range(0, 7) != 0);
            cls      = 2'($urandom_range(0, 2));
            rd       = 5'($urandom_range(0, 3));
            wr       = ($urandom_range(0, 3) != 0);
            rs       = 5'($urandom_range(0, 3));
            rt       = 5'($urandom_range(0, 3));
            use_rs   = $urandom_range(0, 1) != 0;
            use_rt   = $urandom_range(0, 1) != 0;
            flush    = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the in-order MIPS pipeline. It replaces the fixed load-use detector and the separate forwarding unit with one block. A scoreboard tracks in-flight destination registers across DEPTH post-ID stages, with a configurable load latency and a multi-cycle multiply mode. It drives PC/IF-ID hold, IF-ID clear, ID-EX bubble, a global freeze, and registered forwarding selects consumed in EX.

Parameters:
REG_AW, 5, register address width
DEPTH, 3, post-ID stages holding results (slot1=EX … slotDEPTH=WB); legal 2..8
LOAD_LAT, 2, stages after ID until load data is forwardable; legal 1..DEPTH-1
MUL_LAT, 4, EX occupancy of a MUL in cycles; legal 1..16
CNT_W, 16, stall counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active low
id_valid_i  in  1  ID holds a real instruction
id_rs_i  in  REG_AW  source A address
id_rt_i  in  REG_AW  source B address
id_use_rs_i  in  1  instruction reads rs
id_use_rt_i  in  1  instruction reads rt
id_rd_i  in  REG_AW  destination address
id_wr_i  in  1  instruction writes a register
id_class_i  in  2  ALU=0, LOAD=1, MUL=2
flush_i  in  1  taken branch/jump resolved in ID
pc_hold_o  out  1  PC keeps its value
ifid_hold_o  out  1  IF/ID keeps its contents
ifid_clear_o  out  1  IF/ID loads a bubble
idex_bubble_o  out  1  ID/EX loads a bubble
freeze_o  out  1  all pipeline registers hold
fwd_rs_o  out  FW=$clog2(DEPTH+1)  EX operand-A source: 0=reg file, k=result of slot k
fwd_rt_o  out  FW  EX operand-B source, same coding
stall_cnt_o  out  CNT_W  saturating count of stall and freeze cycles

Behaviour:
- Reset (rst_i=0 at a clock edge): all slots invalid, rdy_cnt=0, FSM=IDLE, fwd_*=0, stall_cnt=0. All outputs read 0 on the following cycle. Reset during BUSY returns to IDLE with no residual freeze.
- Slot contents: valid, dest, wr, rdy_cnt.
- Match rule: a source matches a slot when it is used, the slot is valid, the slot's wr=1, dest==source, and dest!=0. Only the youngest (lowest-index) match counts.
- stall = id_valid_i & FSM=IDLE & any youngest match with rdy_cnt>0.
  - On stall: pc_hold_o=ifid_hold_o=idex_bubble_o=1 in the same cycle (combinational).
- busy = FSM=BUSY. freeze_o=busy. Under freeze every pipeline register holds, the scoreboard does not shift, and counters do not decrement.
- ifid_clear_o = flush_i & ~stall & ~busy. Stall and busy take priority because branch operands are not yet valid.
- Scoreboard advance (not frozen):
  - slot1 takes the issued instruction, or invalid if stall or !id_valid_i.
  - slot k+1 takes slot k; slotDEPTH is dropped.
  - Every rdy_cnt decrements, saturating at 0.
- Issue rdy_cnt: ALU=0, MUL=0, LOAD=LOAD_LAT-1.
- Forward select:
  - Registered on issue.
  - Youngest match in slot j gives code j+1 if j+1<=DEPTH, else 0.
  - No match gives 0.
  - Held during freeze; 0 on a bubble.
  - The reg file must provide write-through for same-cycle WB.
- FSM:
  - IDLE→BUSY when a MUL issues and MUL_LAT>1. A load counter is set to MUL_LAT-1.
  - BUSY decrements the counter each cycle; BUSY→IDLE when it reaches 1.
  - Freeze lasts exactly MUL_LAT-1 cycles.
- stall_cnt increments on any cycle with stall|busy and saturates at all-ones.
- All combinational outputs are glitch-free functions of the registered state and the inputs. No latency beyond what is stated.

Decomposition:
- Shared package hazard_pkg: class encodings (CLS_ALU/LOAD/MUL), FWD_REGFILE=0, FSM state encoding.
- One sub-module, hazard_match: combinational youngest-slot priority matcher. Instantiated once per source operand; outputs hit, slot index, and rdy_cnt>0.

Test Plan:
- LOAD r8, then ADD r9,r8,r1 back-to-back (DEPTH=3, LOAD_LAT=2) → exactly 1 stall cycle (pc_hold/ifid_hold/idex_bubble=1). ADD reaches EX with fwd_rs_o=2. stall_cnt=1.
- ADD r8; SUB uses r8; OR uses r8 → no stall. fwd_rs_o=1 for SUB, 2 for OR. A fourth dependent instruction gets 3, the fifth gets 0.
- MUL r5 (MUL_LAT=4) → freeze_o=1 for 3 cycles. Scoreboard frozen. A dependent instruction then issues with fwd=1. stall_cnt=3.
- Write to r0 followed by a reader of r0; then load followed by a dependent with flush_i=1 in the stall cycle → no stall for r0. In the load case the stall is taken and ifid_clear_o=0 during the stall.
- rst_i=0 in the 2nd BUSY cycle → next cycle freeze_o=0, fwd=0, stall_cnt=0, all slots empty. A following load-use pair behaves as after a cold reset.
- Param sweep DEPTH=5, LOAD_LAT=3: load then dependent → 2 stall cycles, fwd_rs_o=3. Saturation with CNT_W=2 → counter holds at 3.
